p4_arbiter: RTL and testbench

Round-robin scheduler that shares one combinational P4 adder between `NREQ` requesters. It accepts operand pairs over per-requester valid/ready handshakes and drives the adder's A/B/CIN inputs from registers. It samples the sum and carry-out after a programmable settle time, then returns the result with the requester ID over a single response handshake. It sits between the requesting datapath blocks and the adder's `p4_port`.

---
 rtl/p4_arbiter_pkg.sv | 24 ++
 rtl/p4_rr_arbiter.sv | 35 +++
 rtl/p4_arbiter.sv | 130 +++++++++++++
 tb/tb_p4_arbiter.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/p4_arbiter_pkg.sv
// Shared types and helpers for the P4 adder round-robin scheduler.
package p4_arb_pkg;

   // Scheduler FSM: idle/accept, adder settle wait, response hold.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } arb_state_t;

   // Widest requester vector and ID the index helper handles.
   localparam int MAX_REQ = 32;
   localparam int MAX_IDW = 5;

   // Index of the set bit in a one-hot (or zero) vector; zero maps to 0.
   function automatic logic [MAX_IDW-1:0] onehot2idx(input logic [MAX_REQ-1:0] oh);
      logic [MAX_IDW-1:0] idx;
      idx = '0;
      for (int i = 0; i < MAX_REQ; i++)
         if (oh[i]) idx = idx | MAX_IDW'(i);
      return idx;
   endfunction

endpackage

// File: rtl/p4_rr_arbiter.sv
// Combinational round-robin picker: highest priority is last_grant+1,
// wrapping modulo NREQ.
import p4_arb_pkg::*;

module p4_rr_arbiter #(
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  last_grant,
   output logic [NREQ-1:0] gnt,
   output logic [IDW-1:0]  gnt_idx
);

   logic [NREQ-1:0] mask;
   logic [NREQ-1:0] req_hi;
   logic [NREQ-1:0] gnt_hi;
   logic [NREQ-1:0] gnt_lo;

   // Requesters strictly above the last winner get first look.
   always_comb begin
      mask = '0;
      for (int i = 0; i < NREQ; i++)
         mask[i] = (IDW'(i) > last_grant);
   end

   assign req_hi = req & mask;
   // Lowest set bit isolates the winner in each half of the rotation.
   assign gnt_hi = req_hi & (~req_hi + NREQ'(1));
   assign gnt_lo = req & (~req + NREQ'(1));
   assign gnt    = (req_hi != '0) ? gnt_hi : gnt_lo;

   assign gnt_idx = IDW'(onehot2idx(MAX_REQ'(gnt)));

endmodule

// File: rtl/p4_arbiter.sv
// Round-robin scheduler sharing one combinational P4 adder among NREQ
// requesters. add_a/add_b/add_cin drive the adder's p4_port inputs and
// add_s/add_cout come back from it; the sum is sampled SETTLE cycles after
// the operands are registered and returned over a single response handshake.
import p4_arb_pkg::*;

module p4_arbiter #(
   parameter int DWIDTH = 32,
   parameter int NREQ   = 4,
   parameter int SETTLE = 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NREQ-1:0]          req_valid,
   output logic [NREQ-1:0]          req_ready,
   input  logic [NREQ*DWIDTH-1:0]   req_a,
   input  logic [NREQ*DWIDTH-1:0]   req_b,
   input  logic [NREQ-1:0]          req_cin,
   output logic [DWIDTH-1:0]        add_a,
   output logic [DWIDTH-1:0]        add_b,
   output logic                     add_cin,
   input  logic [DWIDTH-1:0]        add_s,
   input  logic                     add_cout,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [$clog2(NREQ)-1:0]  rsp_id,
   output logic [DWIDTH-1:0]        rsp_sum,
   output logic                     rsp_cout,
   output logic                     busy,
   output logic [31:0]              op_count
);

   localparam int IDW = $clog2(NREQ);
   localparam int CW  = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   if (SETTLE < 1) begin : g_bad_settle
      $error("p4_arbiter: SETTLE must be at least 1");
   end
   if (NREQ < 2 || NREQ > MAX_REQ) begin : g_bad_nreq
      $error("p4_arbiter: NREQ out of range");
   end

   arb_state_t                   state;
   logic [CW-1:0]                cnt;
   logic [IDW-1:0]               last_grant;
   logic [NREQ-1:0]              gnt;
   logic [IDW-1:0]               gnt_idx;
   logic [NREQ-1:0][DWIDTH-1:0]  ra;
   logic [NREQ-1:0][DWIDTH-1:0]  rb;

   // Per-requester operand views so the grant index selects a whole word.
   for (genvar i = 0; i < NREQ; i++) begin : g_unpack
      assign ra[i] = req_a[i*DWIDTH +: DWIDTH];
      assign rb[i] = req_b[i*DWIDTH +: DWIDTH];
   end

   p4_rr_arbiter #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_rr (
      .req        (req_valid),
      .last_grant (last_grant),
      .gnt        (gnt),
      .gnt_idx    (gnt_idx)
   );

   // Accept is only offered while idle; the handshake completes same cycle.
   assign req_ready = (state == ST_IDLE) ? gnt : '0;
   assign busy      = (state != ST_IDLE);

   // Scheduler FSM with registered adder operands and response.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         last_grant <= IDW'(NREQ-1);
         add_a      <= '0;
         add_b      <= '0;
         add_cin    <= 1'b0;
         rsp_valid  <= 1'b0;
         rsp_id     <= '0;
         rsp_sum    <= '0;
         rsp_cout   <= 1'b0;
         op_count   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (|req_valid) begin
                  // add_* are left untouched while idle to keep the adder quiet.
                  add_a      <= ra[gnt_idx];
                  add_b      <= rb[gnt_idx];
                  add_cin    <= req_cin[gnt_idx];
                  last_grant <= gnt_idx;
                  cnt        <= CW'(SETTLE-1);
                  state      <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (cnt == '0) begin
                  rsp_sum   <= add_s;
                  rsp_cout  <= add_cout;
                  rsp_id    <= last_grant;
                  rsp_valid <= 1'b1;
                  state     <= ST_RESP;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  op_count  <= op_count + 32'd1;
                  state     <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // At most one requester is accepted per cycle.
   a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n)
      $onehot0(req_ready));

   // A stalled response must not change under the consumer.
   a_rsp_hold: assert property (@(posedge clk) disable iff (!rst_n)
      (rsp_valid && !rsp_ready) |=> (rsp_valid && $stable(rsp_sum) &&
                                     $stable(rsp_id) && $stable(rsp_cout)));

endmodule

// File: tb/tb_p4_arbiter.sv
// Scoreboard bench for p4_arbiter: expected responses are queued when
// stimulus is issued and popped by per-DUT monitors on each handshake.
module tb_p4_arbiter;

   localparam int DW = 32;
   localparam int NR = 4;

   typedef struct {
      logic [1:0]    id;
      logic [DW-1:0] sum;
      logic          cout;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail = 0;
   exp_t q0[$];
   exp_t q1[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // DUT0: SETTLE=1 with an ideal combinational adder
   logic [NR-1:0]    req_valid, req_ready, req_cin;
   logic [NR*DW-1:0] req_a, req_b;
   logic [DW-1:0]    add_a, add_b, add_s, rsp_sum;
   logic             add_cin, add_cout, rsp_valid, rsp_ready, rsp_cout, busy;
   logic [1:0]       rsp_id;
   logic [31:0]      op_count;

   assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_cin};

   p4_arbiter #(.DWIDTH(DW), .NREQ(NR), .SETTLE(1)) dut0 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
      .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
      .add_s(add_s), .add_cout(add_cout),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .busy(busy), .op_count(op_count));

   // DUT1: SETTLE=3 with an adder whose output lags its inputs by two cycles
   logic [NR-1:0]    req_valid1, req_ready1, req_cin1;
   logic [NR*DW-1:0] req_a1, req_b1;
   logic [DW-1:0]    add_a1, add_b1, add_s1, rsp_sum1;
   logic             add_cin1, add_cout1, rsp_valid1, rsp_ready1, rsp_cout1, busy1;
   logic [1:0]       rsp_id1;
   logic [31:0]      op_count1;
   logic [DW:0]      slow1, slow2;

   always @(posedge clk) begin
      slow1 <= {1'b0, add_a1} + {1'b0, add_b1} + {32'd0, add_cin1};
      slow2 <= slow1;
   end
   assign {add_cout1, add_s1} = slow2;

   p4_arbiter #(.DWIDTH(DW), .NREQ(NR), .SETTLE(3)) dut1 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid1), .req_ready(req_ready1),
      .req_a(req_a1), .req_b(req_b1), .req_cin(req_cin1),
      .add_a(add_a1), .add_b(add_b1), .add_cin(add_cin1),
      .add_s(add_s1), .add_cout(add_cout1),
      .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1), .rsp_id(rsp_id1),
      .rsp_sum(rsp_sum1), .rsp_cout(rsp_cout1), .busy(busy1), .op_count(op_count1));

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic timeout(input string nm);
      n_tests++;
      n_fail++;
      $display("FAIL %s: timed out waiting for DUT", nm);
   endtask

   task automatic set_req(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic c);
      req_a[i*DW +: DW] = a;
      req_b[i*DW +: DW] = b;
      req_cin[i] = c;
   endtask

   task automatic push0(input logic [1:0] id, input logic [DW-1:0] s, input logic c);
      exp_t e;
      e.id = id; e.sum = s; e.cout = c;
      q0.push_back(e);
   endtask

   task automatic wait_grant(input bit which, input string nm,
                             output logic [NR-1:0] g, output int t);
      g = '0;
      t = -1;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if ((which ? req_ready1 : req_ready) != '0) begin
            g = which ? req_ready1 : req_ready;
            t = cyc;
            return;
         end
      end
      timeout(nm);
   endtask

   task automatic wait_rsp(input bit which, input string nm, output int t);
      t = -1;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if ((which ? rsp_valid1 : rsp_valid) == 1'b1) begin
            t = cyc;
            return;
         end
      end
      timeout(nm);
   endtask

   task automatic wait_drain(input bit which, input string nm);
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (which ? (q1.size() == 0 && !busy1) : (q0.size() == 0 && !busy0_w())) break;
      end
      chk(nm, which ? q1.size() : q0.size(), 0);
   endtask

   function automatic logic busy0_w();
      return busy;
   endfunction

   // Response monitors: pop and compare on every completed handshake.
   always @(negedge clk) begin
      if (rst_n && rsp_valid && rsp_ready) begin
         if (q0.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL rsp0_unexpected: got id %0d sum %0h, none expected", rsp_id, rsp_sum);
         end else begin
            exp_t e;
            e = q0.pop_front();
            chk("rsp0_id", rsp_id, e.id);
            chk("rsp0_sum", rsp_sum, e.sum);
            chk("rsp0_cout", rsp_cout, e.cout);
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && rsp_valid1 && rsp_ready1) begin
         if (q1.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL rsp1_unexpected: got id %0d sum %0h, none expected", rsp_id1, rsp_sum1);
         end else begin
            exp_t e;
            e = q1.pop_front();
            chk("rsp1_id", rsp_id1, e.id);
            chk("rsp1_sum", rsp_sum1, e.sum);
            chk("rsp1_cout", rsp_cout1, e.cout);
         end
      end
   end

   initial begin
      logic [NR-1:0] g;
      int t, t2, tprev;
      exp_t e;
      req_valid = '0; req_a = '0; req_b = '0; req_cin = '0; rsp_ready = 1'b1;
      req_valid1 = '0; req_a1 = '0; req_b1 = '0; req_cin1 = '0; rsp_ready1 = 1'b1;
      tprev = 0;

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_ready_cin", {req_ready, add_cin}, 0);
      chk("rst_add_ab", {add_a, add_b}, 0);
      chk("rst_rsp", {rsp_valid, rsp_cout, rsp_id, rsp_sum}, 0);
      chk("rst_busy_cnt", {busy, op_count}, 0);
      @(posedge clk); #1 rst_n = 1'b1;

      // all four continuously valid: grants 0,1,2,3,0, three cycles apart
      for (int i = 0; i < NR; i++) set_req(i, 32'h100 * (i + 1), i, i[0]);
      push0(2'd0, 32'h100, 1'b0);
      push0(2'd1, 32'h202, 1'b0);
      push0(2'd2, 32'h302, 1'b0);
      push0(2'd3, 32'h404, 1'b0);
      push0(2'd0, 32'h100, 1'b0);
      @(posedge clk); #1 req_valid = '1;
      for (int k = 0; k < 5; k++) begin
         wait_grant(0, "rr_grant", g, t);
         chk("rr_order", g, 4'b0001 << (k % 4));
         if (k > 0) chk("rr_interval", t - tprev, 3);
         tprev = t;
      end
      @(posedge clk); #1 req_valid = '0;
      wait_drain(0, "rr_drain");

      // single request with overflow: FFFFFFFF + 1 from req 2
      set_req(2, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
      push0(2'd2, 32'h0, 1'b1);
      @(posedge clk); #1 req_valid = 4'b0100;
      wait_grant(0, "ovf_grant", g, t);
      chk("ovf_grant", g, 4'b0100);
      @(posedge clk); #1 req_valid = '0;
      wait_rsp(0, "ovf_rsp", t2);
      chk("ovf_latency", t2 - t, 2);
      @(negedge clk);
      chk("ovf_opcount", op_count, 6);

      // response stall: rsp_ready low, requester keeps asking
      @(posedge clk); #1 rsp_ready = 1'b0;
      set_req(1, 32'd5, 32'd7, 1'b0);
      push0(2'd1, 32'd12, 1'b0);
      push0(2'd1, 32'd12, 1'b0);
      req_valid = 4'b0010;
      wait_grant(0, "stall_grant", g, t);
      chk("stall_grant", g, 4'b0010);
      wait_rsp(0, "stall_rsp", t2);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("stall_valid", rsp_valid, 1);
         chk("stall_data", {rsp_id, rsp_sum, rsp_cout}, {2'd1, 32'd12, 1'b0});
         chk("stall_ready", req_ready, 0);
      end
      @(posedge clk); #1 rsp_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("stall_idle_busy", busy, 0);
      chk("stall_idle_grant", req_ready, 4'b0010);
      @(posedge clk); #1 req_valid = '0;
      wait_drain(0, "stall_drain");

      // op_count wrap from 2^32-1
      @(posedge clk); #1 force dut0.op_count = 32'hFFFF_FFFF;
      #1 release dut0.op_count;
      @(negedge clk);
      chk("wrap_preload", op_count, 32'hFFFF_FFFF);
      set_req(0, 32'h1234, 32'h1, 1'b0);
      push0(2'd0, 32'h1235, 1'b0);
      @(posedge clk); #1 req_valid = 4'b0001;
      wait_grant(0, "wrap_grant", g, t);
      chk("wrap_grant", g, 4'b0001);
      @(posedge clk); #1 req_valid = '0;
      wait_drain(0, "wrap_drain");
      chk("wrap_opcount", op_count, 0);

      // SETTLE=3 on dut1, only the final WAIT-cycle sum is sampled
      req_a1[DW-1:0] = 32'h1234_5678;
      req_b1[DW-1:0] = 32'h1111_1111;
      req_cin1[0] = 1'b1;
      e.id = 2'd0; e.sum = 32'h2345_678A; e.cout = 1'b0;
      q1.push_back(e);
      @(posedge clk); #1 req_valid1 = 4'b0001;
      wait_grant(1, "s3_grant", g, t);
      chk("s3_grant", g, 4'b0001);
      @(posedge clk); #1 req_valid1 = '0;
      wait_rsp(1, "s3_rsp", t2);
      chk("s3_latency", t2 - t, 4);
      wait_drain(1, "s3_drain");

      // reset during WAIT aborts the operation
      set_req(3, 32'd1, 32'd1, 1'b1);
      @(posedge clk); #1 req_valid = 4'b1000;
      wait_grant(0, "abort_grant", g, t);
      chk("abort_grant", g, 4'b1000);
      @(posedge clk); #1 req_valid = '0;
      #1 rst_n = 1'b0;
      #1;
      chk("abort_busy_ready", {busy, req_ready}, 0);
      chk("abort_add", {add_a, add_b}, 0);
      chk("abort_cin_rsp", {add_cin, rsp_valid, rsp_cout, rsp_id, rsp_sum}, 0);
      #1 rst_n = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("abort_no_rsp", rsp_valid, 0);
      end
      set_req(0, 32'd7, 32'd8, 1'b0);
      push0(2'd0, 32'd15, 1'b0);
      @(posedge clk); #1 req_valid = 4'b1001;
      wait_grant(0, "abort_next_grant", g, t);
      chk("abort_next_grant", g, 4'b0001);
      @(posedge clk); #1 req_valid = '0;
      wait_drain(0, "abort_drain");
      chk("abort_opcount", op_count, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
